// File: rtl/display_pkg.sv
// Shared constants, segment patterns and the double-dabble step for the
// result display path.
package display_pkg;

  localparam int unsigned BIN_W        = 16;
  localparam int unsigned DABBLE_STEPS = 16;
  localparam int unsigned MAX_DISPLAY  = 9999;

  // Segment patterns are active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } conv_state_t;

  // One iteration: add 3 to every BCD nibble >= 5, then shift {bcd,bin} left
  function automatic logic [31:0] dabble_step(input logic [31:0] s);
    logic [31:0] t;
    t = s;
    for (int k = 0; k < 4; k++) begin
      if (t[16+4*k +: 4] >= 4'd5) t[16+4*k +: 4] = t[16+4*k +: 4] + 4'd3;
    end
    return {t[30:0], 1'b0};
  endfunction

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    logic [6:0] r;
    r = SEG_BLANK;
    for (int i = 0; i < 10; i++) begin
      if (d == 4'(i)) r = SEG_DIGIT[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 16-bit binary to 4-digit BCD converter (double dabble);
// result, overflow and a one-cycle done are presented in the COMMIT cycle.
module bin2bcd_seq
  import display_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic [BIN_W-1:0] bcd,
  output logic             overflow,
  output logic             done
);

  localparam int unsigned ITER_W = 4;

  conv_state_t       state, state_nxt;
  logic [31:0]       work_q, work_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              ovf_q, ovf_d;
  logic              done_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (iter_q == ITER_W'(DABBLE_STEPS - 1)) state_nxt = COMMIT;
      COMMIT:  state_nxt = start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath next values; a start is honoured in IDLE and in COMMIT
  always_comb begin
    work_d = work_q;
    iter_d = iter_q;
    ovf_d  = ovf_q;
    done_d = (state_nxt == COMMIT);
    if (state == SHIFT) begin
      work_d = dabble_step(work_q);
      iter_d = iter_q + 1'b1;
    end else if (start) begin
      work_d = {16'h0000, bin};
      iter_d = '0;
      ovf_d  = (bin > BIN_W'(MAX_DISPLAY));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      work_q <= '0;
      iter_q <= '0;
      ovf_q  <= 1'b0;
      done   <= 1'b0;
    end else begin
      work_q <= work_d;
      iter_q <= iter_d;
      ovf_q  <= ovf_d;
      done   <= done_d;
    end
  end

  assign bcd      = work_q[31:16];
  assign overflow = ovf_q;

endmodule

// File: rtl/result_display_scanner.sv
// Converts the calculator result to BCD and scans it onto a 4-digit
// common-anode 7-segment display with leading-zero blanking and overflow dashes.
module result_display_scanner
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] value,
  input  logic             load,
  input  logic             blank_lz,
  output logic [6:0]       seg,
  output logic [3:0]       an,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

  logic [BIN_W-1:0] conv_bcd;
  logic             conv_ovf;
  logic             conv_done;
  logic             start_c;
  logic [BIN_W-1:0] src_c;

  logic             pend_q;
  logic [BIN_W-1:0] pend_val_q;
  logic [BIN_W-1:0] disp_q;
  logic             ovf_q;
  logic             busy_q;

  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       idx_q;
  logic             tick_c;
  logic [6:0]       seg_q, seg_c;
  logic [3:0]       an_q;
  logic [3:0]       nib_c;
  logic             lead_zero_c;

  // Converter is free when idle or in its COMMIT cycle; pending takes priority
  assign start_c = (load | pend_q) & (~busy_q | conv_done);
  assign src_c   = pend_q ? pend_val_q : value;

  bin2bcd_seq u_conv (
    .clk      (clk),
    .rst      (rst),
    .start    (start_c),
    .bin      (src_c),
    .bcd      (conv_bcd),
    .overflow (conv_ovf),
    .done     (conv_done)
  );

  // One-deep pending slot, last load wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q     <= 1'b0;
      pend_val_q <= '0;
    end else if (load && !(start_c && !pend_q)) begin
      pend_q     <= 1'b1;
      pend_val_q <= value;
    end else if (start_c) begin
      pend_q     <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_q <= '0;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      if (conv_done) begin
        if (conv_ovf) begin
          ovf_q <= 1'b1;
        end else begin
          ovf_q  <= 1'b0;
          disp_q <= conv_bcd;
        end
      end
      busy_q <= start_c | (busy_q & ~conv_done);
    end
  end

  assign tick_c = (cnt_q == CNT_W'(REFRESH_DIV - 1));

  // A digit is a leading zero when it and every digit above it are zero
  always_comb begin
    nib_c       = disp_q[{idx_q, 2'b00} +: 4];
    lead_zero_c = blank_lz && (idx_q != 2'd0) && ((disp_q >> {idx_q, 2'b00}) == '0);
    if (ovf_q)            seg_c = SEG_DASH;
    else if (lead_zero_c) seg_c = SEG_BLANK;
    else                  seg_c = digit_seg(nib_c);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      idx_q <= 2'd0;
      seg_q <= SEG_BLANK;
      an_q  <= 4'hF;
    end else begin
      cnt_q <= tick_c ? '0 : cnt_q + 1'b1;
      if (tick_c) begin
        idx_q <= idx_q + 1'b1;
        seg_q <= seg_c;
        an_q  <= ~(4'b0001 << idx_q);
      end
    end
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_result_display_scanner.sv
// Scoreboard bench for result_display_scanner: stimulus queues the expected
// scanned frame, a monitor captures a full scan after each conversion ends.
module tb_result_display_scanner;

  localparam int unsigned DIV = 4;

  logic        clk;
  logic        rst;
  logic [15:0] value;
  logic        load;
  logic        blank_lz;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        busy;

  typedef struct packed {
    logic [27:0] frame;
    logic [7:0]  run_len;
  } exp_t;

  exp_t exp_q[$];
  int   total  = 0;
  int   passed = 0;

  localparam logic [6:0] SEG_TAB [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  result_display_scanner #(.REFRESH_DIV(DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .value    (value),
    .load     (load),
    .blank_lz (blank_lz),
    .seg      (seg),
    .an       (an),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // Reference: what the four digit slots should show for a committed value
  function automatic logic [27:0] model_frame(input int unsigned v, input bit blz);
    logic [27:0] f;
    int unsigned p;
    p = 1;
    for (int k = 0; k < 4; k++) begin
      if (v > 9999)                 f[7*k +: 7] = 7'b0111111;
      else if (blz && k > 0 && v < p) f[7*k +: 7] = 7'h7F;
      else                          f[7*k +: 7] = SEG_TAB[(v / p) % 10];
      p = p * 10;
    end
    return f;
  endfunction

  task automatic capture_check(input logic [27:0] exp);
    logic [27:0] got;
    logic [3:0]  seen;
    logic [3:0]  prev_an;
    int          bad;
    got = '0; seen = '0; bad = 0; prev_an = 4'hF;
    for (int i = 0; i < 200 && rst !== 1'b1; i++) @(negedge clk);
    repeat (DIV + 2) @(negedge clk);
    for (int i = 0; i < 4 * DIV; i++) begin
      @(negedge clk);
      case (an)
        4'b1110: begin got[6:0]   = seg; seen[0] = 1'b1; end
        4'b1101: begin got[13:7]  = seg; seen[1] = 1'b1; end
        4'b1011: begin got[20:14] = seg; seen[2] = 1'b1; end
        4'b0111: begin got[27:21] = seg; seen[3] = 1'b1; end
        default: bad++;
      endcase
      if (prev_an != 4'hF && an != prev_an)
        check("scan_order", 32'(an), 32'({prev_an[2:0], prev_an[3]}));
      prev_an = an;
    end
    check("anode_onehot", 32'(bad), 32'd0);
    check("digits_seen", 32'(seen), 32'hF);
    for (int k = 0; k < 4; k++)
      check($sformatf("digit%0d", k), 32'(got[7*k +: 7]), 32'(exp[7*k +: 7]));
  endtask

  task automatic pop_and_check(input int run);
    exp_t e;
    if (exp_q.size() == 0) begin
      total++;
      $display("FAIL unexpected_output: conversion ended with nothing expected");
    end else begin
      e = exp_q.pop_front();
      if (e.run_len != 8'd0) check("busy_len", 32'(run), 32'(e.run_len));
      capture_check(e.frame);
    end
  endtask

  // Monitor: every busy fall (or reset release) triggers a frame capture
  initial begin : monitor
    int   run;
    logic busy_prev;
    run = 0;
    busy_prev = 1'b0;
    @(posedge rst);
    pop_and_check(0);
    forever begin
      @(negedge clk);
      if (busy === 1'b1) begin
        run++;
        busy_prev = 1'b1;
      end else if (busy_prev) begin
        pop_and_check(run);
        run = 0;
        busy_prev = busy;
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 300 && busy !== 1'b0; i++) @(negedge clk);
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic txn(input logic [15:0] v, input bit blz);
    exp_t e;
    blank_lz  = blz;
    e.frame   = model_frame(v, blz);
    e.run_len = 8'd17;
    exp_q.push_back(e);
    @(negedge clk);
    value = v; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("busy_rise", 32'(busy), 32'd1);
    wait_idle();
    repeat (30) @(negedge clk);
  endtask

  // Loads spaced by gaps[i] cycles; the last value is what ends up displayed
  task automatic burst(input logic [15:0] vals[$], input int gaps[$], input bit blz, input int run);
    exp_t e;
    blank_lz  = blz;
    e.frame   = model_frame(vals[vals.size()-1], blz);
    e.run_len = 8'(run);
    exp_q.push_back(e);
    @(negedge clk);
    value = vals[0]; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int i = 1; i < vals.size(); i++) begin
      repeat (gaps[i-1] - 1) @(negedge clk);
      value = vals[i]; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
    end
    wait_idle();
    repeat (30) @(negedge clk);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    logic [15:0] vals[$];
    int          gaps[$];
    exp_t        e;
    logic [15:0] rv;
    int          n;

    rst = 1'b0; load = 1'b0; value = '0; blank_lz = 1'b1;
    e.frame = model_frame(0, 1'b1); e.run_len = 8'd0;
    exp_q.push_back(e);
    repeat (3) @(negedge clk);
    check("reset_seg", 32'(seg), 32'h7F);
    check("reset_an", 32'(an), 32'hF);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 20 && an === 4'hF; i++) @(negedge clk);
    check("first_tick_an", 32'(an), 32'hE);
    check("first_tick_seg", 32'(seg), 32'h40);
    repeat (30) @(negedge clk);

    txn(16'd1234, 1'b1);
    txn(16'd7, 1'b1);
    txn(16'd7, 1'b0);
    txn(16'd1005, 1'b1);
    txn(16'd0, 1'b1);
    txn(16'd10000, 1'b1);
    txn(16'd65535, 1'b0);
    txn(16'd9999, 1'b1);

    vals = '{16'd42, 16'd500, 16'd81};
    gaps = '{3, 2};
    burst(vals, gaps, 1'b1, 34);

    // Reset in the 8th SHIFT cycle of a conversion
    blank_lz = 1'b1;
    e.frame = model_frame(0, 1'b1); e.run_len = 8'd0;
    exp_q.push_back(e);
    @(negedge clk);
    value = 16'd4321; load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("midreset_seg", 32'(seg), 32'h7F);
    check("midreset_an", 32'(an), 32'hF);
    check("midreset_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);

    for (int t = 0; t < 20; t++) begin
      vals = {};
      gaps = {};
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 3))
          0:       rv = 16'($urandom_range(0, 99));
          1:       rv = 16'($urandom_range(10000, 65535));
          default: rv = 16'($urandom_range(0, 9999));
        endcase
        vals.push_back(rv);
        if (i > 0) gaps.push_back(int'($urandom_range(1, 3)));
      end
      if (n == 1) txn(vals[0], 1'($urandom_range(0, 1)));
      else        burst(vals, gaps, 1'($urandom_range(0, 1)), 0);
    end

    repeat (40) @(negedge clk);
    check("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
